// File: rtl/shift2d_pkg.sv
// Shared constants for the 2-D word shift register family.
package shift2d_pkg;

   // Default geometry, shared with the 2-D shift register.
   localparam int unsigned DEFAULT_WIDTH = 4;
   localparam int unsigned DEFAULT_DEPTH = 16;

   // State encoding for the unloader FSM.
   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   // Slot holding the oldest word at the default depth.
   localparam int unsigned LAST_SLOT = DEFAULT_DEPTH - 1;

   typedef enum logic {
      StIdle  = ST_IDLE,
      StShift = ST_SHIFT
   } state_e;

   // Index of the oldest slot for an arbitrary depth.
   function automatic int unsigned last_slot(input int unsigned depth);
      return depth - 1;
   endfunction

endpackage

// File: rtl/shift2d_word_counter.sv
// Word counter for a snapshot replay: clears synchronously, counts transfers, flags
// the final word. Saturates at DEPTH-1 rather than wrapping.
module shift2d_word_counter #(
   parameter int unsigned DEPTH = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic last_o
);

   localparam int unsigned CntW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEPTH - 1);

   logic [CntW-1:0] count_q, count_d;

   assign last_o = (count_q == CntMax);

   // Next count: clear wins over increment; hold once the terminal value is reached.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && !last_o) begin
         count_d = count_q + CntW'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/shift_reg2d_unloader.sv
// Parallel-in, word-serial-out unloader: captures a DEPTH x WIDTH snapshot and replays
// it oldest-slot-first under a valid/ready handshake.
module shift_reg2d_unloader
   import shift2d_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   LOAD,
   input  logic [WIDTH*DEPTH-1:0] DATA_IN,
   output logic [WIDTH-1:0]       OUT,
   output logic                   OUT_VALID,
   input  logic                   OUT_READY,
   output logic                   OUT_LAST,
   output logic                   BUSY,
   output logic                   DONE
);

   localparam int unsigned TopSlot = last_slot(DEPTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] storage_q [DEPTH];
   logic [WIDTH-1:0] storage_d [DEPTH];
   logic             done_q, done_d;
   logic             cnt_clr, cnt_inc, cnt_last;
   logic             busy;

   shift2d_word_counter #(
      .DEPTH(DEPTH)
   ) u_counter (
      .clk_i (CLK),
      .rst_i (RESET),
      .clr_i (cnt_clr),
      .inc_i (cnt_inc),
      .last_o(cnt_last)
   );

   // Next state: capture on LOAD in idle, shift toward the top slot on each transfer,
   // clear everything and pulse DONE after the final word.
   always_comb begin
      state_d   = state_q;
      storage_d = storage_q;
      done_d    = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (LOAD) begin
               for (int k = 0; k < DEPTH; k++) begin
                  storage_d[k] = DATA_IN[k*WIDTH +: WIDTH];
               end
               cnt_clr = 1'b1;
               state_d = StShift;
            end
         end
         StShift: begin
            if (OUT_READY) begin
               if (cnt_last) begin
                  state_d   = StIdle;
                  storage_d = '{default: '0};
                  done_d    = 1'b1;
                  cnt_clr   = 1'b1;
               end else begin
                  for (int k = DEPTH - 1; k > 0; k--) begin
                     storage_d[k] = storage_q[k-1];
                  end
                  storage_d[0] = '0;
                  cnt_inc      = 1'b1;
               end
            end
         end
      endcase
   end

   // State, storage and DONE registers; reset discards any partial snapshot.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= StIdle;
         storage_q <= '{default: '0};
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         storage_q <= storage_d;
         done_q    <= done_d;
      end
   end

   assign busy      = (state_q == StShift);
   assign BUSY      = busy;
   assign OUT_VALID = busy;
   assign OUT       = busy ? storage_q[TopSlot] : '0;
   assign OUT_LAST  = busy & cnt_last;
   assign DONE      = done_q;

endmodule

// File: tb/tb_shift_reg2d_unloader.sv
// Scoreboard bench for shift_reg2d_unloader: default 4x16 instance plus an 8x2 instance.
module tb_shift_reg2d_unloader;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   // Default-geometry DUT
   logic        LOAD = 1'b0;
   logic [63:0] DATA_IN = '0;
   logic [3:0]  OUT;
   logic        OUT_VALID, OUT_LAST, BUSY, DONE;
   logic        OUT_READY = 1'b0;
   // 8-bit x 2 DUT
   logic        load2 = 1'b0;
   logic [15:0] data2 = '0;
   logic [7:0]  out2;
   logic        valid2, last2, busy2, done2;
   logic        ready2 = 1'b0;

   int tests = 0;
   int failed = 0;
   int xfer_cnt = 0;
   int done_cnt = 0;
   int xfer2 = 0;
   logic [8:0] q [$];   // {last, word}
   logic [8:0] q2 [$];

   always #5 CLK = ~CLK;

   shift_reg2d_unloader u_dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .LOAD     (LOAD),
      .DATA_IN  (DATA_IN),
      .OUT      (OUT),
      .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY),
      .OUT_LAST (OUT_LAST),
      .BUSY     (BUSY),
      .DONE     (DONE)
   );

   shift_reg2d_unloader #(
      .WIDTH(8),
      .DEPTH(2)
   ) u_dut2 (
      .CLK      (CLK),
      .RESET    (RESET),
      .LOAD     (load2),
      .DATA_IN  (data2),
      .OUT      (out2),
      .OUT_VALID(valid2),
      .OUT_READY(ready2),
      .OUT_LAST (last2),
      .BUSY     (busy2),
      .DONE     (done2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops and compares on every handshake of the main DUT.
   always @(negedge CLK) begin
      if (OUT_VALID && OUT_READY && !RESET) begin
         xfer_cnt++;
         if (q.size() == 0) begin
            chk("unexpected_word", {27'd0, OUT_LAST, OUT}, 32'h1ff);
         end else begin
            chk("word", {27'd0, OUT_LAST, OUT}, {23'd0, q.pop_front()});
         end
      end
      if (DONE) done_cnt++;
   end

   // Monitor for the 8x2 DUT.
   always @(negedge CLK) begin
      if (valid2 && ready2 && !RESET) begin
         xfer2++;
         if (q2.size() == 0) begin
            chk("unexpected_word2", {23'd0, last2, out2}, 32'h1ff);
         end else begin
            chk("word2", {23'd0, last2, out2}, {23'd0, q2.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_load(input logic [63:0] d);
      DATA_IN = d;
      LOAD    = 1'b1;
      tick();
      LOAD    = 1'b0;
   endtask

   // Wait for DONE on the main DUT; returns at the negedge where it is seen.
   task automatic wait_done(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge CLK);
         if (DONE) seen = 1'b1;
      end
      chk(name, {31'd0, seen}, 32'd1);
   endtask

   task automatic push_desc();
      for (int i = 15; i >= 0; i--) q.push_back({(i == 0), 4'(i)});
   endtask

   logic [63:0] pat_k, pat_rev, pat_5;

   initial begin
      for (int k = 0; k < 16; k++) begin
         pat_k[k*4 +: 4]   = 4'(k);
         pat_rev[k*4 +: 4] = 4'(15 - k);
      end
      pat_5 = {16{4'h5}};

      // Reset state
      repeat (2) tick();
      RESET = 1'b0;
      @(negedge CLK);
      chk("rst_out", {28'd0, OUT}, 32'd0);
      chk("rst_valid", {31'd0, OUT_VALID}, 32'd0);
      chk("rst_busy", {31'd0, BUSY}, 32'd0);
      chk("rst_done", {31'd0, DONE}, 32'd0);
      chk("rst_last", {31'd0, OUT_LAST}, 32'd0);

      // 1. Basic replay
      tick();
      OUT_READY = 1'b1;
      push_desc();
      do_load(pat_k);
      @(negedge CLK);
      chk("t1_latency_valid", {31'd0, OUT_VALID}, 32'd1);
      chk("t1_first_word", {28'd0, OUT}, 32'hf);
      wait_done("t1_done_seen");
      chk("t1_busy_in_done", {31'd0, BUSY}, 32'd0);
      repeat (3) tick();
      chk("t1_done_pulses", done_cnt, 32'd1);
      chk("t1_xfers", xfer_cnt, 32'd16);
      chk("t1_queue_empty", q.size(), 32'd0);
      chk("t1_busy_after", {31'd0, BUSY}, 32'd0);

      // 2. Backpressure on cycles 3-6
      xfer_cnt = 0;
      push_desc();
      do_load(pat_k);
      tick();
      tick();
      OUT_READY = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         chk("t2_stall_word", {28'd0, OUT}, 32'hd);
         chk("t2_stall_last", {31'd0, OUT_LAST}, 32'd0);
         tick();
      end
      OUT_READY = 1'b1;
      wait_done("t2_done_seen");
      repeat (2) tick();
      chk("t2_xfers", xfer_cnt, 32'd16);
      chk("t2_queue_empty", q.size(), 32'd0);

      // 3. LOAD while busy is ignored, LOAD in DONE cycle accepted
      xfer_cnt = 0;
      done_cnt = 0;
      push_desc();
      do_load(pat_k);
      repeat (4) tick();
      DATA_IN = pat_5;
      LOAD    = 1'b1;
      wait_done("t3_done_seen");
      chk("t3_idle_in_done", {31'd0, BUSY}, 32'd0);
      for (int i = 0; i < 16; i++) q.push_back({(i == 15), 4'h5});
      tick();
      LOAD = 1'b0;
      @(negedge CLK);
      chk("t3_reload_valid", {31'd0, OUT_VALID}, 32'd1);
      chk("t3_reload_word", {28'd0, OUT}, 32'h5);
      wait_done("t3_done2_seen");
      repeat (2) tick();
      chk("t3_xfers", xfer_cnt, 32'd32);
      chk("t3_done_pulses", done_cnt, 32'd2);
      chk("t3_queue_empty", q.size(), 32'd0);

      // 4. Reset after the 7th transfer
      xfer_cnt = 0;
      for (int i = 15; i >= 9; i--) q.push_back({1'b0, 4'(i)});
      do_load(pat_k);
      repeat (7) tick();
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      @(negedge CLK);
      chk("t4_out", {28'd0, OUT}, 32'd0);
      chk("t4_valid", {31'd0, OUT_VALID}, 32'd0);
      chk("t4_busy", {31'd0, BUSY}, 32'd0);
      chk("t4_xfers", xfer_cnt, 32'd7);
      chk("t4_queue_empty", q.size(), 32'd0);
      tick();
      xfer_cnt = 0;
      for (int i = 0; i < 16; i++) q.push_back({(i == 15), 4'(i)});
      do_load(pat_rev);
      wait_done("t4_done_seen");
      repeat (2) tick();
      chk("t4_fresh_xfers", xfer_cnt, 32'd16);
      chk("t4_fresh_queue_empty", q.size(), 32'd0);

      // 5. RESET and LOAD at the same edge, mid-snapshot
      q.push_back({1'b0, 4'hf});
      q.push_back({1'b0, 4'he});
      do_load(pat_k);
      tick();
      tick();
      RESET   = 1'b1;
      LOAD    = 1'b1;
      DATA_IN = pat_5;
      tick();
      RESET = 1'b0;
      LOAD  = 1'b0;
      @(negedge CLK);
      chk("t5_busy", {31'd0, BUSY}, 32'd0);
      chk("t5_valid", {31'd0, OUT_VALID}, 32'd0);
      chk("t5_out", {28'd0, OUT}, 32'd0);
      chk("t5_queue_empty", q.size(), 32'd0);
      tick();
      chk("t5_still_idle", {31'd0, BUSY}, 32'd0);

      // 6. 8-bit x 2 variant
      ready2 = 1'b1;
      q2.push_back({1'b0, 8'ha5});
      q2.push_back({1'b1, 8'h3c});
      data2 = {8'ha5, 8'h3c};
      load2 = 1'b1;
      tick();
      load2 = 1'b0;
      @(negedge CLK);
      chk("t6_first", {24'd0, out2}, 32'ha5);
      tick();
      tick();
      @(negedge CLK);
      chk("t6_done", {31'd0, done2}, 32'd1);
      chk("t6_busy", {31'd0, busy2}, 32'd0);
      chk("t6_xfers", xfer2, 32'd2);
      chk("t6_queue_empty", q2.size(), 32'd0);

      repeat (2) tick();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
